// File: rtl/timer_irq_responder_pkg.sv
// timer_irq_responder_pkg: register word offsets (Address[4:2]), TCON bit positions and default window base.
package timer_irq_responder_pkg;
   localparam logic [31:0] DEFAULT_BASE = 32'h4000_0000;
   localparam logic [2:0]  OFF_TH       = 3'd0;
   localparam logic [2:0]  OFF_TL       = 3'd1;
   localparam logic [2:0]  OFF_TCON     = 3'd2;
   localparam logic [2:0]  OFF_PSC      = 3'd3;
   localparam logic [2:0]  OFF_SYSTICK  = 3'd5;
   localparam int          TCON_EN      = 0;
   localparam int          TCON_IE      = 1;
   localparam int          TCON_IS      = 2;
endpackage

// File: rtl/timer_irq_responder_prescaler.sv
// timer_prescaler: turns the counting enable into one tick every i_psc+1 cycles; a PSC write restarts the count.
module timer_prescaler #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_en,
   input  logic [W-1:0] i_psc,
   input  logic         i_clr,
   output logic         o_tick
);
   logic [W-1:0] r_pc;
   assign o_tick = i_en & (r_pc == i_psc);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_pc <= '0;
      else        r_pc <= (i_clr | ~i_en | o_tick) ? '0 : r_pc + 1'b1;
endmodule

// File: rtl/timer_irq_responder.sv
// timer_irq_responder: memory-mapped reloadable interval timer, TCON, systick and level IRQ.
// Define TIMER_PRESCALE_EN to add the PSC register and tick prescaler at offset 0x0C.
module timer_irq_responder
   import timer_irq_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE,
   parameter logic [31:0] TH_RST     = 32'h0000_0000,
   parameter int          PRESCALE_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] Write_data,
   input  logic        MemRead,
   input  logic        MemWrite,
   output logic [31:0] Read_data,
   output logic        hit,
   output logic        IRQ
);
   logic [31:0] r_th, r_tl, r_systick;
   logic        r_en, r_ie, r_is;
   logic [2:0]  w_off;
   logic        w_wr, w_tick, w_ovf, w_unused;
   logic [31:0] w_rdata, w_psc_rd;
   assign hit      = Address[31:5] == BASE_ADDR[31:5];
   assign w_off    = Address[4:2];
   assign w_wr     = hit & MemWrite;
   assign w_ovf    = w_tick & (r_tl == 32'hFFFF_FFFF);
   assign IRQ      = r_ie & r_is;
   assign w_unused = &{1'b0, Address[1:0], PRESCALE_W[0]};
`ifdef TIMER_PRESCALE_EN
   logic [PRESCALE_W-1:0] r_psc;
   logic                  w_psc_wr;
   assign w_psc_wr = w_wr & (w_off == OFF_PSC);
   assign w_psc_rd = 32'(r_psc);
   always_ff @(posedge clk or negedge reset)
      if (!reset)        r_psc <= '0;
      else if (w_psc_wr) r_psc <= Write_data[PRESCALE_W-1:0];
   timer_prescaler #(.W(PRESCALE_W)) u_prescaler (
      .clk    (clk),
      .rst_n  (reset),
      .i_en   (r_en),
      .i_psc  (r_psc),
      .i_clr  (w_psc_wr),
      .o_tick (w_tick)
   );
`else
   assign w_psc_rd = '0;
   assign w_tick   = r_en;
`endif
   always_comb begin
      w_rdata = '0;
      case (w_off)
         OFF_TH:      w_rdata = r_th;
         OFF_TL:      w_rdata = r_tl;
         OFF_TCON:    w_rdata = {29'd0, r_is, r_ie, r_en};
         OFF_PSC:     w_rdata = w_psc_rd;
         OFF_SYSTICK: w_rdata = r_systick;
         default:     w_rdata = '0;
      endcase
   end
   assign Read_data = (hit & MemRead) ? w_rdata : '0;
   // CPU TL write beats the tick; an overflow set of IS beats a same-edge W1C
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_th      <= TH_RST;
         r_tl      <= '0;
         r_systick <= '0;
         r_en      <= 1'b0;
         r_ie      <= 1'b0;
         r_is      <= 1'b0;
      end else begin
         r_systick <= r_systick + 1'b1;
         if (w_wr & (w_off == OFF_TH)) r_th <= Write_data;
         if (w_wr & (w_off == OFF_TL)) r_tl <= Write_data;
         else if (w_tick)              r_tl <= w_ovf ? r_th : r_tl + 1'b1;
         if (w_wr & (w_off == OFF_TCON)) begin
            r_en <= Write_data[TCON_EN];
            r_ie <= Write_data[TCON_IE];
         end
         if (w_ovf & r_ie)                                          r_is <= 1'b1;
         else if (w_wr & (w_off == OFF_TCON) & Write_data[TCON_IS]) r_is <= 1'b0;
      end
endmodule

// File: tb/tb_timer_irq_responder.sv
// tb_timer_irq_responder: randomized bench; a register-array model feeds expected reads/IRQ into queues
// that a negedge monitor pops whenever the DUT presents a read.
`timescale 1ns/1ps
module tb_timer_irq_responder;
   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam logic [31:0] THR  = 32'h0000_0000;
`ifdef TIMER_PRESCALE_EN
   localparam bit PRESC = 1'b1;
`else
   localparam bit PRESC = 1'b0;
`endif
   logic        clk = 0, reset = 0, MemRead = 0, MemWrite = 0, hit, IRQ;
   logic [31:0] Address = 0, Write_data = 0, Read_data;
   int          checks = 0, passed = 0;
   logic [31:0] rd_q[$];
   logic [1:0]  cyc_q[$];
   logic [31:0] m_reg[8];
   int          m_pc;

   always #5 clk = ~clk;

   timer_irq_responder dut (
      .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
      .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(Read_data), .hit(hit), .IRQ(IRQ)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic void m_reset();
      foreach (m_reg[i]) m_reg[i] = 32'h0;
      m_reg[0] = THR;
      m_pc = 0;
   endfunction

   function automatic logic [31:0] wmask(input int off);
      return (off < 2) ? 32'hFFFF_FFFF : (off == 3 && PRESC) ? 32'h0000_00FF : 32'h0;
   endfunction

   // One clock edge of the register map, from the old values and this cycle's bus access
   function automatic void m_step(input logic [31:0] a, input logic [31:0] d, input bit wr);
      logic [31:0] nxt[8];
      int  off = int'(a[4:2]);
      bit  acc = wr && (a[31:5] == BASE[31:5]);
      bit  en = m_reg[2][0], ie = m_reg[2][1], tick, set = 0;
      nxt = m_reg;
      if (PRESC) begin
         tick = en && (m_pc == int'(m_reg[3]));
         m_pc = (en && !tick) ? m_pc + 1 : 0;
      end else tick = en;
      if (tick) begin
         nxt[1] = (m_reg[1] == 32'hFFFF_FFFF) ? m_reg[0] : m_reg[1] + 1;
         set = (m_reg[1] == 32'hFFFF_FFFF) && ie;
      end
      if (acc && off == 2) begin
         nxt[2][1:0] = d[1:0];
         if (d[2]) nxt[2][2] = 1'b0;
      end else if (acc) nxt[off] = (nxt[off] & ~wmask(off)) | (d & wmask(off));
      if (acc && off == 3 && PRESC) m_pc = 0;
      if (set) nxt[2][2] = 1'b1;
      nxt[5] = m_reg[5] + 1;
      m_reg = nxt;
   endfunction

   task automatic op(input logic [31:0] a, input logic [31:0] d, input bit rd, input bit wr);
      bit in = a[31:5] == BASE[31:5];
      Address = a; Write_data = d; MemRead = rd; MemWrite = wr;
      if (rd && in) rd_q.push_back(m_reg[a[4:2]]);
      cyc_q.push_back({in, m_reg[2][1] & m_reg[2][2]});
      if (reset) m_step(a, d, wr);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      MemRead = 0; MemWrite = 0;
      #2 reset = 0;
      m_reset();
      #1 check("async_irq", 32'(IRQ), 32'h0);
   endtask

   task automatic rand_ops(input int n);
      for (int i = 0; i < n; i++) begin
         int          sel = $urandom_range(0, 8);
         logic [31:0] a = (sel == 8) ? $urandom : BASE + 32'(sel * 4) + 32'($urandom_range(0, 3));
         logic [31:0] d = $urandom;
         if (sel < 2 && $urandom_range(0, 1)) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         if (sel == 2) d = 32'($urandom_range(0, 7)) | ($urandom_range(0, 3) == 0 ? 32'h0 : 32'h1);
         if (sel == 3) d = 32'($urandom_range(0, 4));
         op(a, d, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
      end
   endtask

   always @(negedge clk) begin : monitor
      logic [1:0] e;
      if (cyc_q.size() > 0) begin
         e = cyc_q.pop_front();
         check("hit", 32'(hit), 32'(e[1]));
         check("irq", 32'(IRQ), 32'(e[0]));
      end
      if (MemRead && hit) begin
         if (rd_q.size() == 0) begin
            checks++;
            $display("FAIL read: unexpected read data %h with no expected value", Read_data);
         end else check("rdata", Read_data, rd_q.pop_front());
      end
   end

   initial begin
      m_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1;
      for (int o = 0; o < 8; o++) op(BASE + 32'(o * 4), 32'h0, 1, 0);
      repeat (10) op(32'h0, 32'h0, 0, 0);
      op(BASE + 32'h14, 32'h0, 1, 0);
      op(BASE, 32'hFFFF_FFFC, 0, 1);
      op(BASE + 4, 32'hFFFF_FFFC, 0, 1);
      op(BASE + 8, 32'h3, 0, 1);
      repeat (6) op(BASE + 4, 32'h0, 1, 0);
      op(BASE + 8, 32'h0, 1, 0);
      op(BASE + 8, 32'h7, 0, 1);
      op(BASE + 8, 32'h0, 1, 0);
      op(BASE + 4, 32'hFFFF_FFFE, 0, 1);
      op(BASE + 8, 32'h7, 0, 1);
      op(BASE + 8, 32'h0, 1, 0);
      op(BASE + 8, 32'h5, 0, 1);
      op(BASE + 4, 32'hFFFF_FFFE, 0, 1);
      repeat (4) op(BASE + 4, 32'h0, 1, 0);
      op(BASE + 8, 32'h0, 1, 0);
      op(BASE + 4, 32'h5, 0, 1);
      op(BASE + 4, 32'h0, 1, 0);
      op(BASE + 4, 32'h0, 1, 0);
      op(BASE + 32'h10, 32'h0, 1, 0);
      op(BASE + 32'h20, 32'h0, 1, 0);
      op(BASE + 4, 32'hFFFF_FFFF, 0, 1);
      op(BASE, 32'h0000_0123, 0, 1);
      op(BASE + 4, 32'h0, 1, 0);
      op(BASE + 8, 32'h2, 0, 1);
      op(BASE + 4, 32'h0, 1, 0);
      op(BASE + 4, 32'h0, 1, 0);
      op(BASE + 12, 32'h3, 0, 1);
      op(BASE + 8, 32'h1, 0, 1);
      repeat (10) op(BASE + 4, 32'h0, 1, 0);
      rand_ops(1500);
      do_reset();
      op(BASE + 4, 32'h0, 1, 0);
      op(BASE + 12, 32'h0, 1, 0);
      op(BASE + 8, 32'h0, 1, 0);
      #1 reset = 1;
      rand_ops(500);
      MemRead = 0; MemWrite = 0;
      @(negedge clk); #1;
      check("leftover_reads", 32'(rd_q.size()), 32'h0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/timer_irq_responder.md
Name: timer_irq_responder

Overview:
- Memory-mapped timer peripheral. Answers the CPU's MEM-stage data-bus accesses and drives the CPU's IRQ input.
- Sits beside the data memory on the MEM-stage address/data bus. Returns read data combinationally in the same cycle; commits writes on the clock edge.
- Holds a reloadable 32-bit interval timer, a control/status register and a free-running cycle counter (systick).

Parameters:
BASE_ADDR, 32'h4000_0000, byte address of register window; bits [4:0] must be zero
TH_RST, 32'h0000_0000, reset value of the TH reload register
PRESCALE_W, 8, width of the prescaler divide register; used only with TIMER_PRESCALE_EN

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
Address  input  32  byte address from the MEM stage
Write_data  input  32  store data
MemRead  input  1  load strobe
MemWrite  input  1  store strobe
Read_data  output  32  load data; combinational
hit  output  1  Address is inside the window; selects Read_data over the data memory
IRQ  output  1  level interrupt request to the CPU

Behaviour:
- Window decode:
  - hit = (Address[31:5] == BASE_ADDR[31:5]), independent of the strobes.
  - Register offsets use Address[4:2]: 0x00 TH (rw), 0x04 TL (rw), 0x08 TCON (rw), 0x0C PSC (rw, only with the macro), 0x14 SYSTICK (ro).
  - Other offsets: reads return 0, writes are ignored.
- Read_data = (hit & MemRead) ? selected register : 32'h0. Zero wait states; no handshake. The value read is the register value before the current edge's update.
- Writes take effect on the posedge when hit & MemWrite. Address[1:0] is ignored; only word access is supported.
- TCON layout:
  - bit0 EN: counting enable.
  - bit1 IE: interrupt enable.
  - bit2 IS: interrupt status.
  - bits[31:3] read 0.
  - A write sets EN and IE from Write_data[1:0]. Writing 1 to bit2 clears IS (write-1-to-clear); writing 0 to bit2 leaves IS unchanged.
- Tick: asserted every cycle when EN=1. With the macro, the tick comes from the prescaler instead.
- On a tick:
  - If TL == 32'hFFFF_FFFF: TL <= TH, and if IE=1 then IS <= 1.
  - Otherwise TL <= TL + 1 (32-bit, no carry out).
- Simultaneous events, same edge:
  - CPU write to TL beats the tick increment or reload.
  - Write to TH together with a reload: TL loads the OLD TH; TH takes the new value.
  - Overflow-set of IS beats a W1C clear, so no interrupt is lost.
  - Clearing EN in the same cycle as a tick: the tick still applies this edge.
- IRQ = IE & IS, purely combinational from registers. It stays high until software clears IS or IE.
- SYSTICK increments every cycle regardless of EN and wraps 32'hFFFF_FFFF -> 0. Writes to it are ignored.
- Reset (asynchronous assertion, synchronous-safe deassertion by caller): TH=TH_RST, TL=0, TCON=0, SYSTICK=0, PSC=0, prescaler count=0. Hence IRQ=0. Read_data and hit are combinational and follow their inputs even during reset.
- Reset mid-count: all state is lost immediately. No pending interrupt survives.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- Defined:
  - Adds PSC register (offset 0x0C, bits [PRESCALE_W-1:0], upper bits read 0).
  - Adds an internal count pc.
  - While EN=1: pc increments each cycle; tick = (pc == PSC), and pc resets to 0 on the tick.
  - PSC=0 gives one tick per cycle.
  - EN=0 holds pc at 0.
  - Writing PSC resets pc to 0.
- Undefined: offset 0x0C reads 0 and ignores writes; tick = EN.

Decomposition:
- Shared package: register offset constants (OFF_TH, OFF_TL, OFF_TCON, OFF_PSC, OFF_SYSTICK), TCON bit indices (TCON_EN, TCON_IE, TCON_IS), and the default base address constant.
- One sub-module, timer_prescaler: divide counter producing the tick pulse. Instantiated only under TIMER_PRESCALE_EN.

Test Plan:
1. Reset -> all registers read 0 (TH reads TH_RST); IRQ=0. Read of 0x40000014 after 10 cycles out of reset -> 10 (±1 per the documented edge).
2. TH=32'hFFFF_FFFC, TL=32'hFFFF_FFFC, TCON=3 -> TL reads FFFD, FFFE, FFFF, FFFC on consecutive cycles; IS=1 and IRQ=1 from the reload edge onward.
3. IRQ high, write TCON=32'h7 -> IS=0, IRQ=0, EN/IE stay 1. Repeat the clear on the exact overflow cycle -> IS stays 1.
4. TCON=1 (IE=0) through an overflow -> TL reloads, IS stays 0, IRQ never asserts.
5. Write TL=5 in a cycle where a tick would occur -> TL reads 5, then 6. Read of 0x40000010 -> 0. Address 0x40000020 -> hit=0, Read_data=0.
6. With TIMER_PRESCALE_EN: PSC=3, TCON=1 -> TL increments once every 4 cycles. Toggle reset low mid-count -> TL=0, PSC=0, IRQ=0 asynchronously.
